// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, through a
// single full-subtract cell and a borrow flip-flop, with a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bf_q, bf_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic             bit_diff;
    logic             bit_borrow;
    logic [WIDTH-1:0] work_next;

    // Full-subtract cell on the current LSBs and the carried borrow.
    assign bit_diff   = sa_q[0] ^ sb_q[0] ^ bf_q;
    assign bit_borrow = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bf_q);
    assign work_next  = {bit_diff, work_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        bf_d     = bf_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    work_d  = '0;
                    cnt_d   = '0;
                    bf_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d   = sa_q >> 1;
                sb_d   = sb_q >> 1;
                work_d = work_next;
                bf_d   = bit_borrow;
                cnt_d  = cnt_q + CW'(1);
                // Visible results update only here, so they hold through SHIFT.
                if (cnt_q == LAST_BIT) begin
                    diff_d   = work_next;
                    borrow_d = bit_borrow;
                    zero_d   = (work_next == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            bf_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            bf_q     <= bf_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8 and 16: directed handshake/timing cases
// plus random regression against plain-arithmetic subtraction.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    logic        start8, busy8, done8, borrow8, zero8;
    logic [7:0]  a8, b8, diff8;
    logic        start16, busy16, done16, borrow16, zero16;
    logic [15:0] a16, b16, diff16;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .zero(zero16)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected {borrow, diff} for each accepted operation, oldest first.
    logic [8:0]  exp8_q[$];
    logic [16:0] exp16_q[$];
    logic [8:0]  e8;
    logic [16:0] e16;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            check("done8_expected", 32'(exp8_q.size() != 0), 32'd1);
            if (exp8_q.size() != 0) begin
                e8 = exp8_q.pop_front();
                check("diff8", 32'(diff8), 32'(e8[7:0]));
                check("borrow8", 32'(borrow8), 32'(e8[8]));
                check("zero8", 32'(zero8), 32'(e8[7:0] == 8'h00));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done16) begin
            check("done16_expected", 32'(exp16_q.size() != 0), 32'd1);
            if (exp16_q.size() != 0) begin
                e16 = exp16_q.pop_front();
                check("diff16", 32'(diff16), 32'(e16[15:0]));
                check("borrow16", 32'(borrow16), 32'(e16[16]));
                check("zero16", 32'(zero16), 32'(e16[15:0] == 16'h0000));
            end
        end
    end

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle8_reached", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle16();
        int n = 0;
        @(negedge clk);
        while (busy16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle16_reached", 32'(busy16), 32'd0);
    endtask

    task automatic wait_done8();
        int n = 0;
        @(negedge clk);
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done8_seen", 32'(done8), 32'd1);
    endtask

    // Issue one operation; returns #1 after the accepting edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        wait_idle8();
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        exp8_q.push_back(model8(a, b));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        wait_idle16();
        start16 = 1'b1;
        a16 = a;
        b16 = b;
        exp16_q.push_back(model16(a, b));
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
    endtask

    // Operation with cycle-exact busy/done checks and result-hold checks.
    task automatic op8_timed(input logic [7:0] a, input logic [7:0] b, input logic [7:0] prev);
        op8(a, b);
        check("busy_after_accept", 32'(busy8), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check("busy_during_op", 32'(busy8), 32'd1);
            check("done_timing", 32'(done8), 32'(k == 8));
            if (k < 8) check("diff_held", 32'(diff8), 32'(prev));
        end
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy8), 32'd0);
        check("done_single", 32'(done8), 32'd0);
    endtask

    int t_done[3];

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0;  a8 = '0;  b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        #1;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        check("rst_borrow8", 32'(borrow8), 32'd0);
        check("rst_zero8", 32'(zero8), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_diff16", 32'(diff16), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases with timing.
        op8_timed(8'h5A, 8'h23, 8'h00);
        op8_timed(8'h10, 8'h20, 8'h37);
        op8_timed(8'h00, 8'hFF, 8'hF0);
        op8_timed(8'h77, 8'h77, 8'h01);

        // Start pulses and operand churn during SHIFT are ignored.
        op8(8'h05, 8'h03);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start8 = ((i % 2) == 0);
            a8 = (i == 0) ? 8'hFF : 8'($urandom);
            b8 = (i == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        // Start raised only in the DONE cycle must not launch an operation.
        start8 = 1'b1;
        a8 = 8'h44;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("done_cycle_start_ignored", 32'(busy8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("still_idle", 32'(busy8), 32'd0);

        // Start held high: back-to-back operations every WIDTH + 2 cycles.
        wait_idle8();
        start8 = 1'b1;
        a8 = 8'h9C;
        b8 = 8'h3E;
        repeat (3) exp8_q.push_back(model8(8'h9C, 8'h3E));
        for (int i = 0; i < 3; i++) begin
            wait_done8();
            t_done[i] = cyc;
        end
        start8 = 1'b0;
        check("b2b_spacing_0", 32'(t_done[1] - t_done[0]), 32'd10);
        check("b2b_spacing_1", 32'(t_done[2] - t_done[1]), 32'd10);

        // Reset mid-operation aborts without a done pulse.
        op8(8'h12, 8'h34);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(borrow8), 32'd0);
        check("abort_zero", 32'(zero8), 32'd0);
        exp8_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done8), 32'd0);
        check("abort_idle", 32'(busy8), 32'd0);
        op8(8'hC8, 8'h64);
        wait_done8();

        // Random regression on both widths in parallel.
        fork
            begin
                for (int i = 0; i < 1000; i++) op8(8'($urandom), 8'($urandom));
            end
            begin
                for (int i = 0; i < 1000; i++) op16(16'($urandom), 16'($urandom));
            end
        join

        for (int n = 0; n < 100 && (exp8_q.size() != 0 || exp16_q.size() != 0); n++)
            @(negedge clk);
        check("drain8", 32'(exp8_q.size()), 32'd0);
        check("drain16", 32'(exp16_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
